// File: rtl/ram_bus_arb_pkg.sv
// Shared types and constants for the two-master RAM bus arbiter.
// The round-robin policy is selected by defining ARB_ROUND_ROBIN_EN.
package ram_bus_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Decodes outside every slave, so an idle bus never selects anything.
  localparam logic [ADDR_W-1:0] IDLE_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_bus_arb_pick.sv
// Grant decision for two requesters. Built as round-robin when ARB_ROUND_ROBIN_EN
// is defined, otherwise as fixed priority with M0 winning every tie.
module ram_bus_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie, favour the master that was not granted last.
      grant_id = ~last_grant;
`else
      grant_id = 1'b0;
`endif
    end else if (req1) begin
      grant_id = 1'b1;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter and single-byte transaction sequencer for the shared RAM bus.
// Tie policy: round-robin with ARB_ROUND_ROBIN_EN defined, fixed M0 priority otherwise.
module ram_bus_arbiter
  import ram_bus_arb_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              M0_REQ,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic              M0_WE,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic              M0_ACK,
  input  logic              M1_REQ,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic              M1_WE,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic              M1_ACK,
  output logic [ADDR_W-1:0] BUS_ADDR,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  output logic              BUS_WE,
  output logic              OWNER,
  output logic              BUSY
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              last_grant;
  logic              grant_valid;
  logic              grant_id;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;
  logic              grant_now;

  ram_bus_arb_pick u_pick (
    .req0        (M0_REQ),
    .req1        (M1_REQ),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant_now = (state_q == IDLE) && grant_valid;
  assign win_addr  = grant_id ? M1_ADDR  : M0_ADDR;
  assign win_wdata = grant_id ? M1_WDATA : M0_WDATA;
  assign win_we    = grant_id ? M1_WE    : M0_WE;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  assign last_d     = grant_now ? grant_id : last_q;
  assign last_grant = last_q;

  // Resets to 1 so that M0 takes the first tie.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign last_grant = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wdata_d    = wdata_q;
    bus_addr_d = bus_addr_q;
    bus_we_d   = bus_we_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d    = XFER;
          owner_d    = grant_id;
          wdata_d    = win_wdata;
          bus_addr_d = win_addr;
          bus_we_d   = win_we;
        end
      end
      XFER: begin
        bus_we_d = 1'b0;
        if (bus_we_q) begin
          state_d    = ACK;
          bus_addr_d = IDLE_ADDR;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The slave's registered read data is on the bus for this whole cycle.
        if (owner_q) begin
          rdata1_d = BUS_DATA;
        end else begin
          rdata0_d = BUS_DATA;
        end
        state_d    = ACK;
        bus_addr_d = IDLE_ADDR;
        bus_we_d   = 1'b0;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        bus_addr_d = IDLE_ADDR;
        bus_we_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      wdata_q    <= '0;
      bus_addr_q <= IDLE_ADDR;
      bus_we_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wdata_q    <= wdata_d;
      bus_addr_q <= bus_addr_d;
      bus_we_q   <= bus_we_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Write data is driven only in the write XFER cycle.
  assign BUS_DATA = (state_q == XFER && bus_we_q) ? wdata_q : {DATA_W{1'bz}};

  assign BUS_ADDR = bus_addr_q;
  assign BUS_WE   = bus_we_q;
  assign OWNER    = owner_q;
  assign BUSY     = (state_q != IDLE);
  assign M0_ACK   = (state_q == ACK) && !owner_q;
  assign M1_ACK   = (state_q == ACK) && owner_q;
  assign M0_RDATA = rdata0_q;
  assign M1_RDATA = rdata1_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: table vectors, directed corner cases and
// random traffic checked cycle-by-cycle against a transaction-level reference model.
module tb_ram_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       M0_REQ = 1'b0, M1_REQ = 1'b0;
  logic       M0_WE = 1'b0, M1_WE = 1'b0;
  logic [7:0] M0_ADDR = 8'h00, M1_ADDR = 8'h00;
  logic [7:0] M0_WDATA = 8'h00, M1_WDATA = 8'h00;
  logic [7:0] M0_RDATA, M1_RDATA, BUS_ADDR;
  logic       M0_ACK, M1_ACK, BUS_WE, OWNER, BUSY;
  wire  [7:0] BUS_DATA;

  always #5 CLK = ~CLK;

  ram_bus_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_WE(M0_WE),
    .M0_RDATA(M0_RDATA), .M0_ACK(M0_ACK),
    .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_WE(M1_WE),
    .M1_RDATA(M1_RDATA), .M1_ACK(M1_ACK),
    .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
    .OWNER(OWNER), .BUSY(BUSY)
  );

  // 128x8 RAM slave at 0x00 with a one-cycle registered read output.
  logic [7:0] ram [128];
  logic       slv_drv = 1'b0;
  logic [7:0] slv_data = 8'h00;
  always @(posedge CLK) begin
    if (BUS_WE && BUS_ADDR < 8'h80) ram[BUS_ADDR[6:0]] <= BUS_DATA;
    slv_drv  <= !BUS_WE && (BUS_ADDR < 8'h80);
    slv_data <= ram[BUS_ADDR[6:0]];
  end
  assign BUS_DATA = slv_drv ? slv_data : 8'bz;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  req_t q0[$], q1[$];
  req_t cur [2];
  bit   cur_valid [2];

  // Reference model: one transaction at a time, phases counted from the grant cycle.
  int         m_idle = 0, m_grant = 0, m_ack = 0;
  bit         m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
  req_t       m_txn;
  logic [7:0] mem [128];
  bit         mem_known [128];
  logic [7:0] exp_rd [2];
  bit         rd_known [2];
  bit         scramble = 1'b0;

  int         obs_owner[$];
  int         obs_rdata[$];
  int         obs_lat[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, got, expv);
    end
  endtask

  task automatic drive_pins(input bit m, input bit req, input req_t r);
    if (!m) begin
      M0_REQ = req; M0_WE = r.we; M0_ADDR = r.addr; M0_WDATA = r.wdata;
    end else begin
      M1_REQ = req; M1_WE = r.we; M1_ADDR = r.addr; M1_WDATA = r.wdata;
    end
  endtask

  task automatic push(input bit m, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    if (!m) q0.push_back(r); else q1.push_back(r);
  endtask

  task automatic clear_obs();
    obs_owner.delete(); obs_rdata.delete(); obs_lat.delete();
  endtask

  // One clock: compare outputs for this cycle, then update masters and the model.
  task automatic step();
    bit   busy_e, ack_e, w;
    int   ph;
    req_t junk;
    @(negedge CLK);
    busy_e = m_busy && (cyc > m_grant) && (cyc <= m_ack);
    ack_e  = busy_e && (cyc == m_ack);
    ph     = cyc - m_grant;
    if (ack_e && !m_txn.we) begin
      if (m_txn.addr < 8'h80 && mem_known[m_txn.addr[6:0]]) begin
        exp_rd[m_owner]   = mem[m_txn.addr[6:0]];
        rd_known[m_owner] = 1'b1;
      end else begin
        rd_known[m_owner] = 1'b0;
      end
    end
    chk("busy", int'(BUSY), int'(busy_e));
    chk("m0_ack", int'(M0_ACK), int'(ack_e && !m_owner));
    chk("m1_ack", int'(M1_ACK), int'(ack_e && m_owner));
    chk("bus_we", int'(BUS_WE), int'(busy_e && ph == 1 && m_txn.we));
    chk("bus_addr", int'(BUS_ADDR), (busy_e && cyc < m_ack) ? int'(m_txn.addr) : 8'hFF);
    if (busy_e) chk("owner", int'(OWNER), int'(m_owner));
    if (busy_e && ph == 1 && m_txn.we) chk("bus_wdata", int'(BUS_DATA), int'(m_txn.wdata));
    if (rd_known[0]) chk("m0_rdata", int'(M0_RDATA), int'(exp_rd[0]));
    if (rd_known[1]) chk("m1_rdata", int'(M1_RDATA), int'(exp_rd[1]));

    if (M0_ACK || M1_ACK) begin
      obs_owner.push_back(M1_ACK ? 1 : 0);
      obs_rdata.push_back(M1_ACK ? int'(M1_RDATA) : int'(M0_RDATA));
      obs_lat.push_back(cyc - m_grant);
      $display("txn cyc=%0d m%0d %s addr=%02h wdata=%02h rdata=%02h lat=%0d", cyc,
               M1_ACK ? 1 : 0, m_txn.we ? "WR" : "RD", m_txn.addr, m_txn.wdata,
               M1_ACK ? M1_RDATA : M0_RDATA, cyc - m_grant);
    end

    if (ack_e) begin
      cur_valid[m_owner] = 1'b0;
      drive_pins(m_owner, 1'b0, cur[m_owner]);
      m_busy = 1'b0;
    end

    // Inputs change after the grant; the latched transaction must be unaffected.
    if (scramble && m_busy && ph == 1) begin
      junk.we = 1'($urandom_range(0, 1)); junk.addr = 8'($urandom); junk.wdata = 8'($urandom);
      drive_pins(m_owner, 1'b1, junk);
    end

    if (!cur_valid[0] && q0.size() > 0) begin
      cur[0] = q0.pop_front(); cur_valid[0] = 1'b1; drive_pins(1'b0, 1'b1, cur[0]);
    end
    if (!cur_valid[1] && q1.size() > 0) begin
      cur[1] = q1.pop_front(); cur_valid[1] = 1'b1; drive_pins(1'b1, 1'b1, cur[1]);
    end

    if (cyc == m_idle) begin
      if (cur_valid[0] || cur_valid[1]) begin
        if (cur_valid[0] && cur_valid[1]) w = RR_MODE ? !m_last : 1'b0;
        else w = cur_valid[1];
        m_last  = w;
        m_owner = w;
        m_txn   = cur[w];
        m_grant = cyc;
        m_ack   = cyc + (m_txn.we ? 2 : 3);
        m_busy  = 1'b1;
        m_idle  = m_ack + 1;
        if (m_txn.we && m_txn.addr < 8'h80) begin
          mem[m_txn.addr[6:0]]       = m_txn.wdata;
          mem_known[m_txn.addr[6:0]] = 1'b1;
        end
      end else begin
        m_idle = cyc + 1;
      end
    end
  endtask

  task automatic run_quiet();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || cur_valid[0] || cur_valid[1] || m_busy) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL run_quiet timeout cyc=%0d got=busy required=idle", cyc);
    end
    step();
  endtask

  // Asynchronous reset pulse starting just after a falling edge.
  task automatic do_reset();
    req_t z;
    z = '0;
    #1 RESET = 1'b1;
    drive_pins(1'b0, 1'b0, z);
    drive_pins(1'b1, 1'b0, z);
    q0.delete(); q1.delete();
    cur_valid[0] = 1'b0; cur_valid[1] = 1'b0;
    #1;
    chk("rst_bus_addr", int'(BUS_ADDR), 8'hFF);
    chk("rst_bus_we", int'(BUS_WE), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_m0_ack", int'(M0_ACK), 0);
    chk("rst_m1_ack", int'(M1_ACK), 0);
    chk("rst_m0_rdata", int'(M0_RDATA), 0);
    chk("rst_m1_rdata", int'(M1_RDATA), 0);
    chk("rst_owner", int'(OWNER), 0);
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    m_busy = 1'b0; m_last = 1'b1; scramble = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    m_idle = cyc + 1;
  endtask

  typedef struct {
    bit         m;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         exp_lat;
    int         exp_rd;   // -1: data not checked
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'h10, 8'h5A, 2, -1};
    tbl[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 3, 8'h5A};
    tbl[2] = '{1'b1, 1'b0, 8'h90, 8'h00, 3, -1};
    tbl[3] = '{1'b0, 1'b0, 8'h10, 8'h00, 3, 8'h5A};
    tbl[4] = '{1'b1, 1'b1, 8'h7F, 8'hC3, 2, -1};
    tbl[5] = '{1'b0, 1'b0, 8'h7F, 8'h00, 3, 8'hC3};
    tbl[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 3, 8'h5A};

    @(negedge CLK);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      clear_obs();
      push(tbl[i].m, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      run_quiet();
      chk("tbl_ack_count", obs_owner.size(), 1);
      if (obs_owner.size() > 0) begin
        chk("tbl_owner", obs_owner[0], int'(tbl[i].m));
        chk("tbl_latency", obs_lat[0], tbl[i].exp_lat);
        if (tbl[i].exp_rd >= 0) chk("tbl_rdata", obs_rdata[0], tbl[i].exp_rd);
      end
    end

    // Simultaneous requests from reset: M0 first, then M1.
    do_reset();
    clear_obs();
    push(1'b0, 1'b1, 8'h20, 8'h11);
    push(1'b1, 1'b1, 8'h21, 8'h22);
    run_quiet();
    chk("tie_ack_count", obs_owner.size(), 2);
    if (obs_owner.size() >= 2) begin
      chk("tie_first", obs_owner[0], 0);
      chk("tie_second", obs_owner[1], 1);
    end
    clear_obs();
    push(1'b0, 1'b0, 8'h20, 8'h00);
    run_quiet();
    if (obs_rdata.size() > 0) chk("tie_rd_m0", obs_rdata[0], 8'h11);
    else chk("tie_rd_m0_ack", 0, 1);
    clear_obs();
    push(1'b1, 1'b0, 8'h21, 8'h00);
    run_quiet();
    if (obs_rdata.size() > 0) chk("tie_rd_m1", obs_rdata[0], 8'h22);
    else chk("tie_rd_m1_ack", 0, 1);

    // Both requests held: owner sequence over the first 8 transactions.
    do_reset();
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 1'b1, 8'(8'h40 + i), 8'(i));
      push(1'b1, 1'b1, 8'(8'h50 + i), 8'(8'h80 + i));
    end
    run_quiet();
    chk("hold_ack_count", obs_owner.size(), 16);
    if (obs_owner.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("hold_owner", obs_owner[i], RR_MODE ? (i % 2) : 0);
    end

    // Reset during the WAIT cycle of an M0 read.
    clear_obs();
    push(1'b0, 1'b0, 8'h10, 8'h00);
    begin
      int n = 0;
      step();
      while (!(m_busy && cyc == m_grant + 2) && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) begin
        checks++; errors++;
        $display("FAIL wait_reach timeout cyc=%0d got=not_in_wait required=wait", cyc);
      end
    end
    do_reset();
    repeat (6) step();
    chk("rst_no_ack", obs_owner.size(), 0);
    push(1'b0, 1'b0, 8'h10, 8'h00);
    run_quiet();
    chk("rst_after_ack_count", obs_owner.size(), 1);
    if (obs_rdata.size() > 0) chk("rst_after_rdata", obs_rdata[0], 8'h5A);

    // M0 changes ADDR/WDATA in the cycle after the grant.
    scramble = 1'b1;
    clear_obs();
    push(1'b0, 1'b1, 8'h30, 8'h77);
    run_quiet();
    scramble = 1'b0;
    push(1'b1, 1'b0, 8'h30, 8'h00);
    run_quiet();
    if (obs_rdata.size() >= 2) chk("scramble_rdata", obs_rdata[1], 8'h77);
    else chk("scramble_ack_count", obs_rdata.size(), 2);

    // Random two-master traffic with occasional out-of-RAM addresses.
    scramble = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) &&
            !cur_valid[m] && $urandom_range(0, 2) == 0) begin
          push(1'(m), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 254)) : 8'($urandom_range(0, 127)),
               8'($urandom));
        end
      end
      step();
    end
    run_quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
